// File: rtl/perf_mon_pkg.sv
// Shared types and helpers for the ap_ctrl performance monitor.
package perf_mon_pkg;

  typedef enum logic [2:0] {
    TXN      = 3'd0,
    LAST_LAT = 3'd1,
    MIN_LAT  = 3'd2,
    MAX_LAT  = 3'd3,
    LAT_SUM  = 3'd4,
    LAST_II  = 3'd5,
    STALL    = 3'd6,
    OCC      = 3'd7
  } field_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    BLOCKED = 2'd2
  } chan_state_e;

  // Saturating add at width w (w <= 64); callers zero-extend their operands.
  function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                          input int unsigned w);
    logic [64:0] sum;
    logic [64:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (65'd1 << w) - 65'd1;
    if (sum > lim) begin
      return lim[63:0];
    end else begin
      return sum[63:0];
    end
  endfunction

endpackage

// File: rtl/ap_ctrl_chan_tracker.sv
// One ap_ctrl channel: timestamp FIFO for overlapping transactions,
// channel FSM and latency / II / stall statistics.
module ap_ctrl_chan_tracker
  import perf_mon_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter int  TS_W    = 32,
  parameter int  CNT_W   = 32,
  parameter type stats_t = logic
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            clear,
  input  logic            enable,
  input  logic [TS_W-1:0] ts,
  input  logic            ap_start,
  input  logic            ap_ready,
  input  logic            ap_done,
  input  logic            ap_continue,
  output stats_t          stats,
  output logic            busy,
  output logic            ovf_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] DEPTH_L = OCC_W'(DEPTH);

  logic [TS_W-1:0]  fifo_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [OCC_W-1:0] occ_r;
  logic [CNT_W-1:0] txn_r;
  logic [CNT_W-1:0] last_lat_r;
  logic [CNT_W-1:0] min_lat_r;
  logic [CNT_W-1:0] max_lat_r;
  logic [CNT_W-1:0] lat_sum_r;
  logic [CNT_W-1:0] last_ii_r;
  logic [CNT_W-1:0] stall_r;
  logic [TS_W-1:0]  prev_acc_r;
  logic             has_prev_r;
  logic             ovf_r;
  chan_state_e      state_r;

  logic             acc_s;
  logic             cmp_s;
  logic             stall_s;
  logic             push_s;
  logic             pop_s;
  logic             done_ok_s;
  logic             ovf_s;
  logic [TS_W-1:0]  lat_ts_s;
  logic [TS_W-1:0]  ii_ts_s;
  logic [CNT_W-1:0] lat_s;
  logic [OCC_W-1:0] occ_nxt_s;

  // Classify this cycle's events into FIFO push/pop, completion and error.
  always_comb begin
    acc_s     = ap_start & ap_ready;
    cmp_s     = ap_done & ap_continue;
    stall_s   = ap_done & ~ap_continue;
    push_s    = 1'b0;
    pop_s     = 1'b0;
    done_ok_s = 1'b0;
    ovf_s     = 1'b0;
    lat_ts_s  = '0;
    ii_ts_s   = ts - prev_acc_r;
    if (cmp_s && (occ_r != '0)) begin
      pop_s     = 1'b1;
      push_s    = acc_s;
      done_ok_s = 1'b1;
      lat_ts_s  = ts - fifo_r[rd_ptr_r];
    end else if (cmp_s && acc_s) begin
      // empty FIFO: the accept bypasses straight to completion with zero latency
      done_ok_s = 1'b1;
    end else if (cmp_s) begin
      ovf_s = 1'b1;
    end else if (acc_s) begin
      if (occ_r == DEPTH_L) begin
        ovf_s = 1'b1;
      end else begin
        push_s = 1'b1;
      end
    end else begin
      push_s = 1'b0;
    end
    lat_s = CNT_W'(lat_ts_s);
    if (push_s && !pop_s) begin
      occ_nxt_s = occ_r + OCC_W'(1'b1);
    end else if (pop_s && !push_s) begin
      occ_nxt_s = occ_r - OCC_W'(1'b1);
    end else begin
      occ_nxt_s = occ_r;
    end
  end

  // FIFO, statistics and channel FSM state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) fifo_r[i] <= '0;
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      occ_r      <= '0;
      txn_r      <= '0;
      last_lat_r <= '0;
      min_lat_r  <= '1;
      max_lat_r  <= '0;
      lat_sum_r  <= '0;
      last_ii_r  <= '0;
      stall_r    <= '0;
      prev_acc_r <= '0;
      has_prev_r <= 1'b0;
      ovf_r      <= 1'b0;
      state_r    <= IDLE;
    end else if (clear) begin
      for (int i = 0; i < DEPTH; i++) fifo_r[i] <= '0;
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      occ_r      <= '0;
      txn_r      <= '0;
      last_lat_r <= '0;
      min_lat_r  <= '1;
      max_lat_r  <= '0;
      lat_sum_r  <= '0;
      last_ii_r  <= '0;
      stall_r    <= '0;
      prev_acc_r <= '0;
      has_prev_r <= 1'b0;
      ovf_r      <= 1'b0;
      state_r    <= IDLE;
    end else if (enable) begin
      if (push_s) begin
        fifo_r[wr_ptr_r] <= ts;
        wr_ptr_r         <= wr_ptr_r + PTR_W'(1'b1);
      end
      if (pop_s) rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
      occ_r <= occ_nxt_s;
      if (ovf_s) ovf_r <= 1'b1;
      if (acc_s) begin
        if (has_prev_r) last_ii_r <= CNT_W'(ii_ts_s);
        prev_acc_r <= ts;
        has_prev_r <= 1'b1;
      end
      if (done_ok_s) begin
        last_lat_r <= lat_s;
        if (lat_s < min_lat_r) min_lat_r <= lat_s;
        if (lat_s > max_lat_r) max_lat_r <= lat_s;
        lat_sum_r <= CNT_W'(sat_add(64'(lat_sum_r), 64'(lat_s), CNT_W));
        txn_r     <= CNT_W'(sat_add(64'(txn_r), 64'd1, CNT_W));
      end
      if (stall_s) stall_r <= CNT_W'(sat_add(64'(stall_r), 64'd1, CNT_W));
      if (stall_s) begin
        state_r <= BLOCKED;
      end else if (occ_nxt_s != '0) begin
        state_r <= ACTIVE;
      end else begin
        state_r <= IDLE;
      end
    end
  end

  // Export the statistics record.
  always_comb begin
    stats.txn_count = txn_r;
    stats.last_lat  = last_lat_r;
    stats.min_lat   = min_lat_r;
    stats.max_lat   = max_lat_r;
    stats.lat_sum   = lat_sum_r;
    stats.last_ii   = last_ii_r;
    stats.stall_cnt = stall_r;
    stats.occ       = CNT_W'(occ_r);
  end

  assign busy    = (state_r != IDLE);
  assign ovf_err = ovf_r;

endmodule

// File: rtl/ap_ctrl_perf_monitor.sv
// Multi-channel ap_ctrl performance monitor: timestamp, freeze/clear control,
// per-channel trackers and a registered statistics read port.
module ap_ctrl_perf_monitor
  import perf_mon_pkg::*;
#(
  parameter  int N_CH  = 2,
  parameter  int DEPTH = 4,
  parameter  int TS_W  = 32,
  parameter  int CNT_W = 32,
  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             finish,
  input  logic [N_CH-1:0]  ap_start,
  input  logic [N_CH-1:0]  ap_ready,
  input  logic [N_CH-1:0]  ap_done,
  input  logic [N_CH-1:0]  ap_continue,
  input  logic             rd_req,
  input  logic [CH_W-1:0]  rd_ch,
  input  logic [2:0]       rd_field,
  output logic [CNT_W-1:0] rd_data,
  output logic             rd_valid,
  output logic [N_CH-1:0]  busy,
  output logic [N_CH-1:0]  ovf_err,
  output logic             all_idle
);

  typedef struct packed {
    logic [CNT_W-1:0] txn_count;
    logic [CNT_W-1:0] last_lat;
    logic [CNT_W-1:0] min_lat;
    logic [CNT_W-1:0] max_lat;
    logic [CNT_W-1:0] lat_sum;
    logic [CNT_W-1:0] last_ii;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] occ;
  } chan_stats_t;

  localparam logic [CH_W:0] N_CH_L = (CH_W + 1)'(N_CH);

  logic [TS_W-1:0]  ts_r;
  logic             frozen_r;
  logic [CNT_W-1:0] rd_data_r;
  logic             rd_valid_r;
  chan_stats_t      stats_s [N_CH];
  chan_stats_t      sel_s;
  logic [CNT_W-1:0] rd_mux_s;
  logic [N_CH-1:0]  busy_s;
  logic [N_CH-1:0]  ovf_s;

  // Free-running timestamp; it never freezes.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ts_r <= '0;
    end else if (clear) begin
      ts_r <= '0;
    end else begin
      ts_r <= ts_r + TS_W'(1'b1);
    end
  end

  // Freeze flag: the finish cycle itself still counts, later events do not.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      frozen_r <= 1'b0;
    end else if (clear) begin
      frozen_r <= 1'b0;
    end else if (finish) begin
      frozen_r <= 1'b1;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    ap_ctrl_chan_tracker #(
      .DEPTH  (DEPTH),
      .TS_W   (TS_W),
      .CNT_W  (CNT_W),
      .stats_t(chan_stats_t)
    ) u_trk (
      .clock      (clock),
      .reset      (reset),
      .clear      (clear),
      .enable     (!frozen_r),
      .ts         (ts_r),
      .ap_start   (ap_start[g]),
      .ap_ready   (ap_ready[g]),
      .ap_done    (ap_done[g]),
      .ap_continue(ap_continue[g]),
      .stats      (stats_s[g]),
      .busy       (busy_s[g]),
      .ovf_err    (ovf_s[g])
    );
  end

  // Statistic select; out-of-range channels read as zero.
  always_comb begin
    sel_s    = '0;
    rd_mux_s = '0;
    if ({1'b0, rd_ch} < N_CH_L) begin
      sel_s = stats_s[rd_ch];
      case (field_e'(rd_field))
        TXN:      rd_mux_s = sel_s.txn_count;
        LAST_LAT: rd_mux_s = sel_s.last_lat;
        MIN_LAT:  rd_mux_s = sel_s.min_lat;
        MAX_LAT:  rd_mux_s = sel_s.max_lat;
        LAT_SUM:  rd_mux_s = sel_s.lat_sum;
        LAST_II:  rd_mux_s = sel_s.last_ii;
        STALL:    rd_mux_s = sel_s.stall_cnt;
        OCC:      rd_mux_s = sel_s.occ;
        default:  rd_mux_s = '0;
      endcase
    end else begin
      rd_mux_s = '0;
    end
  end

  // Registered read port; data holds between reads.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_data_r  <= '0;
      rd_valid_r <= 1'b0;
    end else if (clear) begin
      rd_data_r  <= '0;
      rd_valid_r <= 1'b0;
    end else begin
      rd_valid_r <= rd_req;
      if (rd_req) rd_data_r <= rd_mux_s;
    end
  end

  assign rd_data  = rd_data_r;
  assign rd_valid = rd_valid_r;
  assign busy     = busy_s;
  assign ovf_err  = ovf_s;
  assign all_idle = &(~busy_s);

endmodule

// File: tb/tb_ap_ctrl_perf_monitor.sv
// Directed bench: reads are scoreboarded and checked by a separate monitor;
// three channels so that rd_ch=3 is a genuine out-of-range select.
module tb_ap_ctrl_perf_monitor;
  import perf_mon_pkg::*;

  localparam int N_CH  = 3;
  localparam int DEPTH = 4;
  localparam int TS_W  = 32;
  localparam int CNT_W = 32;

  logic             clock = 1'b0;
  logic             reset;
  logic             clear;
  logic             finish;
  logic [N_CH-1:0]  ap_start;
  logic [N_CH-1:0]  ap_ready;
  logic [N_CH-1:0]  ap_done;
  logic [N_CH-1:0]  ap_continue;
  logic             rd_req;
  logic [1:0]       rd_ch;
  logic [2:0]       rd_field;
  logic [CNT_W-1:0] rd_data;
  logic             rd_valid;
  logic [N_CH-1:0]  busy;
  logic [N_CH-1:0]  ovf_err;
  logic             all_idle;

  typedef struct {
    logic [CNT_W-1:0] val;
    string            name;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clock = ~clock;

  ap_ctrl_perf_monitor #(.N_CH(N_CH), .DEPTH(DEPTH), .TS_W(TS_W), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .clear(clear), .finish(finish),
    .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done), .ap_continue(ap_continue),
    .rd_req(rd_req), .rd_ch(rd_ch), .rd_field(rd_field), .rd_data(rd_data),
    .rd_valid(rd_valid), .busy(busy), .ovf_err(ovf_err), .all_idle(all_idle)
  );

  // Monitor: every rd_valid pops one expected read result.
  always @(negedge clock) begin : monitor
    exp_t e;
    if (rd_valid) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rd_valid got=%0h required=no_read", rd_data);
      end else begin
        e = sb_q.pop_front();
        if (rd_data !== e.val) begin
          errors++;
          $display("FAIL %s got=%0h required=%0h", e.name, rd_data, e.val);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [CNT_W-1:0] got, input logic [CNT_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h required=%0h", name, got, exp);
    end
  endtask

  task automatic rd(input int ch, input field_e fld, input logic [CNT_W-1:0] exp, input string name);
    exp_t e;
    e.val  = exp;
    e.name = name;
    sb_q.push_back(e);
    rd_req   = 1'b1;
    rd_ch    = 2'(ch);
    rd_field = fld;
    cyc(1);
    rd_req = 1'b0;
  endtask

  task automatic idle_inputs();
    ap_start = '0; ap_ready = '0; ap_done = '0; ap_continue = '0;
    finish = 1'b0; clear = 1'b0;
  endtask

  initial begin
    reset = 1'b1; rd_req = 1'b0; rd_ch = '0; rd_field = '0;
    idle_inputs();
    #2 reset = 1'b0;
    #1;
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_ovf", 32'(ovf_err), 32'h0);
    chk("reset_all_idle", 32'(all_idle), 32'h1);
    chk("reset_rd_valid", 32'(rd_valid), 32'h0);
    #9 reset = 1'b1;
    cyc(2);
    rd(0, TXN, 32'h0, "reset_txn");
    rd(0, MIN_LAT, 32'hFFFF_FFFF, "reset_min_lat");

    // single transaction on ch0, latency 7
    ap_start[0] = 1'b1; ap_ready[0] = 1'b1; cyc(1); idle_inputs();
    chk("single_busy_active", 32'(busy), 32'h1);
    cyc(6);
    ap_done[0] = 1'b1; ap_continue[0] = 1'b1; cyc(1); idle_inputs();
    chk("single_busy_done", 32'(busy), 32'h0);
    chk("single_all_idle", 32'(all_idle), 32'h1);
    rd(0, TXN, 32'd1, "single_txn");
    rd(0, LAST_LAT, 32'd7, "single_last_lat");
    rd(0, MIN_LAT, 32'd7, "single_min");
    rd(0, MAX_LAT, 32'd7, "single_max");
    rd(0, LAT_SUM, 32'd7, "single_sum");
    rd(0, OCC, 32'd0, "single_occ");
    rd(0, LAST_II, 32'd0, "single_first_ii");

    // pipelined ch1: accepts at +0,+2,+4, completions at +10,+11,+12
    for (int k = 0; k <= 12; k++) begin
      ap_start[1]    = (k == 0 || k == 2 || k == 4);
      ap_ready[1]    = (k == 0 || k == 2 || k == 4);
      ap_done[1]     = (k >= 10);
      ap_continue[1] = (k >= 10);
      if (k == 6) begin
        exp_t e;
        e.val = 32'd3; e.name = "pipe_peak_occ";
        sb_q.push_back(e);
        rd_req = 1'b1; rd_ch = 2'd1; rd_field = OCC;
      end else begin
        rd_req = 1'b0;
      end
      cyc(1);
      if (k == 6) chk("pipe_busy", 32'(busy), 32'h2);
    end
    idle_inputs(); rd_req = 1'b0;
    rd(1, TXN, 32'd3, "pipe_txn");
    rd(1, LAST_LAT, 32'd8, "pipe_last_lat");
    rd(1, MIN_LAT, 32'd8, "pipe_min");
    rd(1, MAX_LAT, 32'd10, "pipe_max");
    rd(1, LAT_SUM, 32'd27, "pipe_sum");
    rd(1, LAST_II, 32'd2, "pipe_ii");
    rd(1, OCC, 32'd0, "pipe_occ_end");

    // overflow: five back-to-back accepts into a depth-4 FIFO
    ap_start[0] = 1'b1; ap_ready[0] = 1'b1; cyc(5); idle_inputs();
    chk("ovf_flag", 32'(ovf_err), 32'h1);
    rd(0, OCC, 32'd4, "ovf_occ");
    rd(0, LAST_II, 32'd1, "ovf_ii");

    // stall: done held without continue for five cycles
    ap_done[0] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cyc(1);
      chk("stall_busy", 32'(busy), 32'h1);
    end
    ap_continue[0] = 1'b1; cyc(1); idle_inputs();
    rd(0, STALL, 32'd5, "stall_cnt");
    rd(0, TXN, 32'd2, "stall_txn");
    rd(0, OCC, 32'd3, "stall_occ");

    // underflow on empty ch1
    ap_done[1] = 1'b1; ap_continue[1] = 1'b1; cyc(1); idle_inputs();
    chk("unf_flag", 32'(ovf_err), 32'h3);
    rd(1, TXN, 32'd3, "unf_txn_unchanged");

    // synchronous clear
    clear = 1'b1; cyc(1); clear = 1'b0;
    chk("clear_busy", 32'(busy), 32'h0);
    chk("clear_ovf", 32'(ovf_err), 32'h0);
    rd(0, MIN_LAT, 32'hFFFF_FFFF, "clear_min_lat");
    rd(0, TXN, 32'd0, "clear_txn");
    rd(1, LAT_SUM, 32'd0, "clear_sum");

    // simultaneous accept and complete on an empty FIFO
    ap_start[0] = 1'b1; ap_ready[0] = 1'b1; ap_done[0] = 1'b1; ap_continue[0] = 1'b1;
    cyc(1); idle_inputs();
    chk("bypass_ovf", 32'(ovf_err), 32'h0);
    chk("bypass_busy", 32'(busy), 32'h0);
    rd(0, LAST_LAT, 32'd0, "bypass_lat");
    rd(0, OCC, 32'd0, "bypass_occ");
    rd(0, TXN, 32'd1, "bypass_txn");

    // freeze: the finish cycle still counts, later events do not
    finish = 1'b1; ap_done[1] = 1'b1; cyc(1); idle_inputs();
    ap_start[0] = 1'b1; ap_ready[0] = 1'b1; cyc(1); idle_inputs();
    cyc(2);
    ap_done[0] = 1'b1; ap_continue[0] = 1'b1; cyc(1); idle_inputs();
    rd(0, TXN, 32'd1, "frozen_txn");
    rd(1, STALL, 32'd1, "finish_cycle_stall");
    rd(3, TXN, 32'd0, "bad_ch_txn");
    rd(3, MIN_LAT, 32'd0, "bad_ch_min");

    // async reset mid-transaction
    clear = 1'b1; cyc(1); clear = 1'b0;
    ap_start[0] = 1'b1; ap_ready[0] = 1'b1; ap_done[1] = 1'b1; ap_continue[1] = 1'b1;
    finish = 1'b1; cyc(1); idle_inputs();
    chk("pre_reset_busy", 32'(busy), 32'h1);
    chk("pre_reset_ovf", 32'(ovf_err), 32'h2);
    rd(0, OCC, 32'd1, "pre_reset_occ");
    #6 reset = 1'b0;
    #1;
    chk("async_busy", 32'(busy), 32'h0);
    chk("async_ovf", 32'(ovf_err), 32'h0);
    chk("async_all_idle", 32'(all_idle), 32'h1);
    chk("async_rd_valid", 32'(rd_valid), 32'h0);
    chk("async_rd_data", rd_data, 32'h0);
    #1 reset = 1'b1;
    cyc(2);
    rd(0, MIN_LAT, 32'hFFFF_FFFF, "post_reset_min");
    ap_start[0] = 1'b1; ap_ready[0] = 1'b1; cyc(1); idle_inputs();
    cyc(2);
    ap_done[0] = 1'b1; ap_continue[0] = 1'b1; cyc(1); idle_inputs();
    rd(0, LAST_LAT, 32'd3, "post_reset_lat");
    rd(0, TXN, 32'd1, "post_reset_txn");

    cyc(3);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got=%0d pending required=0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
